fipo_load_ctrl: RTL
===================

FIPO_LOAD_CTRL -- requirements
Module: fipo_load_ctrl

Interface
REQ-001 The block SHALL have parameter TOTAL_BITS, default 312; the number of bits loaded into the FIPO memory per frame (multiple of 8).
REQ-002 The block SHALL have parameter TIMEOUT, default 16; the maximum number of cycles to wait for fipo_end_writing after the last bit.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: one-cycle request to begin a frame load.
REQ-006 The block SHALL have port abort, input, 1: cancels any load and returns to IDLE.
REQ-007 The block SHALL have port data_in, input, 8: byte of weight data, shifted out MSB first.
REQ-008 The block SHALL have port data_valid, input, 1: data_in is valid.
REQ-009 The block SHALL have port data_ready, output, 1: the block accepts data_in in this cycle.
REQ-010 The block SHALL have port fipo_end_writing, input, 1: the FIPO memory's end-of-write indication.
REQ-011 The block SHALL have port fipo_clr, output, 1: one-cycle reset pulse to the FIPO memory.
REQ-012 The block SHALL have port fipo_enable, output, 1: FIPO write enable.
REQ-013 The block SHALL have port fipo_serial, output, 1: FIPO serial data bit.
REQ-014 The block SHALL have port busy, output, 1: high in any state other than IDLE or DONE.
REQ-015 The block SHALL have port done, output, 1: frame load complete; held until the next start or abort.
REQ-016 The block SHALL have port error, output, 1: the completed frame is faulty; valid while done is high.
REQ-017 The block SHALL have port bit_count, output, 9: number of bits shifted out in the current frame.

Function
REQ-018 The block SHALL implement the states IDLE, CLEAR, WAIT_BYTE, SHIFT, WAIT_END and DONE; all outputs are registered or decoded from state only.
REQ-019 In IDLE or DONE, start=1 SHALL move the FSM to CLEAR, clear bit_count, error and done, and ignore start in every other state.
REQ-020 CLEAR SHALL last exactly one cycle with fipo_clr=1, then move to WAIT_BYTE.
REQ-021 In WAIT_BYTE, data_ready SHALL be 1 and fipo_enable 0; on data_valid=1 the byte is latched into an 8-bit shift register and the FSM moves to SHIFT.
REQ-022 In SHIFT, each cycle SHALL drive fipo_enable=1 and fipo_serial=shift_reg[7], shift left by one and increment bit_count, for exactly 8 cycles per byte.
REQ-023 After the 8th bit of a byte, the FSM SHALL move to WAIT_END if bit_count equals TOTAL_BITS, else to WAIT_BYTE; there are no idle bits between bytes other than the WAIT_BYTE cycles.
REQ-024 data_ready SHALL be 0 in every state except WAIT_BYTE; bytes offered at other times are not consumed.
REQ-025 In WAIT_END, fipo_enable SHALL be 0; fipo_end_writing=1 moves the FSM to DONE with error unchanged; TIMEOUT cycles without fipo_end_writing moves it to DONE with error=1.
REQ-026 fipo_end_writing=1 in WAIT_BYTE or SHIFT (early end) SHALL set a sticky flag, loading continues, and error=1 on entry to DONE.
REQ-027 In DONE, done SHALL be 1 and bit_count SHALL hold TOTAL_BITS.
REQ-028 abort=1 SHALL force IDLE in the next cycle from any state, clearing bit_count, done, error and the shift register; abort has priority over start and data_valid in the same cycle.
REQ-029 bit_count SHALL never exceed TOTAL_BITS and SHALL not wrap.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, with data_ready=0, fipo_clr=0, fipo_enable=0, fipo_serial=0, busy=0, done=0, error=0, bit_count=0 and the shift register at 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; a new start is required after release.

Verification
REQ-032 Nominal frame: start, 39 bytes 0xA5 with data_valid held 1, fipo_end_writing pulsed 2 cycles after the last bit -> fipo_clr for 1 cycle, 312 enabled bits repeating 10100101, done=1, error=0, bit_count=312.
REQ-033 Throttled source: data_valid low for 3 cycles between bytes -> fipo_enable low during the gaps, serial stream identical to REQ-032, done=1.
REQ-034 Timeout: full frame, fipo_end_writing never asserted -> done=1, error=1 exactly TIMEOUT cycles after the last bit.
REQ-035 Early end: fipo_end_writing pulsed at bit 100 -> loading continues to 312, done=1, error=1.
REQ-036 Abort at bit 150 with start in the same cycle -> IDLE next cycle, bit_count=0, done=0, fipo_enable=0; a subsequent start loads a clean frame.
REQ-037 Async reset mid-SHIFT (between clock edges) -> all outputs at reset values immediately; start while busy ignored (bit_count not cleared).

Source files
------------

// File: rtl/fipo_load_ctrl_if.sv
// Handshake and FIPO-side signals of the FIPO load controller.
// The controller takes the slave view; whatever feeds it bytes and
// observes the FIPO side takes the master view.
interface fipo_load_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       fipo_end_writing;
  logic       fipo_clr;
  logic       fipo_enable;
  logic       fipo_serial;
  logic       busy;
  logic       done;
  logic       error;
  logic [8:0] bit_count;

  modport master (
    output start, abort, data_in, data_valid, fipo_end_writing,
    input  data_ready, fipo_clr, fipo_enable, fipo_serial, busy, done, error, bit_count
  );

  modport slave (
    input  start, abort, data_in, data_valid, fipo_end_writing,
    output data_ready, fipo_clr, fipo_enable, fipo_serial, busy, done, error, bit_count
  );
endinterface

// File: rtl/fipo_load_ctrl.sv
// FIPO load controller: clears the FIPO memory, then streams a frame of
// TOTAL_BITS bits into it one bit per cycle, MSB first, taking bytes from a
// valid/ready source. After the last bit it waits up to TIMEOUT cycles for
// the memory's end-of-write indication and then reports done/error.
module fipo_load_ctrl #(
  parameter int TOTAL_BITS = 312,
  parameter int TIMEOUT    = 16
) (
  input logic             clk,
  input logic             rst,
  fipo_load_ctrl_if.slave bus
);

  localparam logic [8:0]    FRAME_BITS = 9'(TOTAL_BITS);
  localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_BYTE,
    SHIFT,
    WAIT_END,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic [8:0]    bit_count_q;
  logic [TW-1:0] timer_q;
  logic          early_q;
  logic          error_q;

  logic last_bit_of_byte;
  logic frame_full;

  assign last_bit_of_byte = (state_q == SHIFT) && (bit_idx_q == 3'd7);
  assign frame_full       = ((bit_count_q + 9'd1) == FRAME_BITS);

  // All outputs are decoded from the state or come straight from registers.
  assign bus.data_ready  = (state_q == WAIT_BYTE);
  assign bus.fipo_clr    = (state_q == CLEAR);
  assign bus.fipo_enable = (state_q == SHIFT);
  assign bus.fipo_serial = (state_q == SHIFT) ? shift_q[7] : 1'b0;
  assign bus.busy        = (state_q != IDLE) && (state_q != DONE);
  assign bus.done        = (state_q == DONE);
  assign bus.error       = error_q;
  assign bus.bit_count   = bit_count_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; abort wins over everything else in the same cycle.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) state_d = CLEAR;
        CLEAR:      state_d = WAIT_BYTE;
        WAIT_BYTE:  if (bus.data_valid) state_d = SHIFT;
        SHIFT:      if (last_bit_of_byte) state_d = frame_full ? WAIT_END : WAIT_BYTE;
        WAIT_END:   if (bus.fipo_end_writing || (timer_q == TIMER_LAST)) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Datapath: shift register, bit counters, end-of-write timer and error flags.
  // The timer counts WAIT_END cycles, so a missing end-of-write is declared
  // after TIMEOUT cycles spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      bit_idx_q   <= '0;
      bit_count_q <= '0;
      timer_q     <= '0;
      early_q     <= 1'b0;
      error_q     <= 1'b0;
    end else if (bus.abort) begin
      shift_q     <= '0;
      bit_idx_q   <= '0;
      bit_count_q <= '0;
      timer_q     <= '0;
      early_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            bit_count_q <= '0;
            early_q     <= 1'b0;
            error_q     <= 1'b0;
          end
        end
        CLEAR: begin
          bit_idx_q <= '0;
          timer_q   <= '0;
        end
        WAIT_BYTE: begin
          if (bus.fipo_end_writing) early_q <= 1'b1;
          if (bus.data_valid) begin
            shift_q   <= bus.data_in;
            bit_idx_q <= '0;
          end
        end
        SHIFT: begin
          if (bus.fipo_end_writing) early_q <= 1'b1;
          shift_q   <= {shift_q[6:0], 1'b0};
          bit_idx_q <= bit_idx_q + 3'd1;
          timer_q   <= '0;
          if (bit_count_q < FRAME_BITS) bit_count_q <= bit_count_q + 9'd1;
        end
        WAIT_END: begin
          if (bus.fipo_end_writing)       error_q <= early_q;
          else if (timer_q == TIMER_LAST) error_q <= 1'b1;
          else                            timer_q <= timer_q + TW'(1);
        end
        default: begin
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule
